// File: rtl/cpu_types_pkg.sv
// Shared datapath types: bus words, the RAM handshake, and the arbiter's
// state and side encodings (testbenches reuse these).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_side_t;

    // One transaction as captured at grant time
    typedef struct packed {
        word_t addr;
        word_t store;
        logic  wen;
    } arb_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Fetch, load/store and RAM-side signals of the arbiter. The arbiter uses the
// slave modport; the CPU/RAM side (or a bench) uses master.
interface ram_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      fault;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, fault
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, fault
    );

endinterface

// File: rtl/wait_timer.sv
// Saturating up-counter with synchronous clear; o_tc flags the last allowed
// cycle (count == MAX-1) so the owner can force completion in that cycle.
module wait_timer #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != W'(MAX))) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == W'(MAX - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported RAM between instruction fetch and data access:
// one latched transaction at a time, alternating on ties, bounded by TIMEOUT.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    ram_arbiter_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_IGRANT = IGRANT;
    localparam logic [1:0] ST_DGRANT = DGRANT;

    logic [1:0] r_state;
    logic [1:0] w_next;
    arb_side_t  r_last;
    arb_req_t   r_req;
    logic       r_fault;

    logic w_ireq, w_dreq;
    logic w_grant_i, w_grant_d;
    logic w_busy, w_tc, w_access, w_err, w_done, w_rd_ok;

    assign w_ireq = bus.iREN;
    assign w_dreq = bus.dREN | bus.dWEN;

    // On a tie the side that did not win last time goes next
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_ireq && w_dreq) begin
                w_grant_d = (r_last == ARB_I);
                w_grant_i = (r_last == ARB_D);
            end else begin
                w_grant_i = w_ireq;
                w_grant_d = w_dreq;
            end
        end
    end

    assign w_busy   = (r_state != ST_IDLE);
    assign w_access = w_busy && (bus.ramstate == ACCESS);
    assign w_err    = w_busy && !w_access && ((bus.ramstate == ERROR) || w_tc);
    assign w_done   = w_access | w_err;
    assign w_rd_ok  = w_access && !r_req.wen;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d)      w_next = ST_DGRANT;
                else if (w_grant_i) w_next = ST_IGRANT;
            end
            ST_IGRANT, ST_DGRANT: begin
                if (w_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_last  <= ARB_I;
            r_req   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_err) r_fault <= 1'b1;
            if (w_grant_i) begin
                r_last <= ARB_I;
                r_req  <= '{addr: bus.iaddr, store: '0, wen: 1'b0};
            end else if (w_grant_d) begin
                r_last <= ARB_D;
                r_req  <= '{addr: bus.daddr, store: bus.dstore, wen: bus.dWEN};
            end
        end
    end

    // Held clear while idle, so every grant starts counting from zero
    wait_timer #(
        .MAX (TIMEOUT),
        .W   (TW)
    ) u_timer (
        .clk   (CLK),
        .rst_n (nRST),
        .i_clr (!w_busy),
        .i_en  (w_busy),
        .o_tc  (w_tc)
    );

    assign bus.ramREN   = w_busy && !r_req.wen;
    assign bus.ramWEN   = w_busy &&  r_req.wen;
    assign bus.ramaddr  = w_busy ? r_req.addr  : '0;
    assign bus.ramstore = w_busy ? r_req.store : '0;

    assign bus.iwait = !((r_state == ST_IGRANT) && w_done);
    assign bus.iload = ((r_state == ST_IGRANT) && w_rd_ok) ? bus.ramload : '0;
    assign bus.dwait = !((r_state == ST_DGRANT) && w_done);
    assign bus.dload = ((r_state == ST_DGRANT) && w_rd_ok) ? bus.ramload : '0;
    assign bus.fault = r_fault;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a transaction-level reference checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    ram_arbiter_if bus();

    ram_arbiter #(.TIMEOUT(TO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    bit run   = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // RAM stub: answers ACCESS after ram_lat BUSY cycles, or ERROR / stuck BUSY
    int ram_lat  = 0;
    bit ram_err  = 1'b0;
    bit ram_hang = 1'b0;
    int ram_cnt  = 0;

    always @(posedge CLK) ram_cnt <= (bus.ramREN | bus.ramWEN) ? ram_cnt + 1 : 0;

    always_comb begin
        if (!(bus.ramREN | bus.ramWEN)) bus.ramstate = FREE;
        else if (ram_err)               bus.ramstate = ERROR;
        else if (ram_hang)              bus.ramstate = BUSY;
        else if (ram_cnt >= ram_lat)    bus.ramstate = ACCESS;
        else                            bus.ramstate = BUSY;
    end

    // Reference: at most one open transaction, its age in cycles, last winner
    bit        m_act   = 1'b0;
    arb_side_t m_side  = ARB_I;
    arb_side_t m_last  = ARB_I;
    word_t     m_addr  = '0;
    word_t     m_data  = '0;
    bit        m_wr    = 1'b0;
    int        m_age   = 0;
    bit        m_fault = 1'b0;

    logic e_access, e_err, e_done;
    always_comb begin
        e_access = m_act && (bus.ramstate == ACCESS);
        e_err    = m_act && !e_access && ((bus.ramstate == ERROR) || (m_age == TO - 1));
        e_done   = e_access || e_err;
    end

    // 0 = nobody, 1 = fetch, 2 = data
    function automatic int winner(bit ir, bit dr, arb_side_t last);
        if (ir && dr) return (last == ARB_I) ? 2 : 1;
        if (ir)       return 1;
        if (dr)       return 2;
        return 0;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_act   <= 1'b0;
            m_side  <= ARB_I;
            m_last  <= ARB_I;
            m_addr  <= '0;
            m_data  <= '0;
            m_wr    <= 1'b0;
            m_age   <= 0;
            m_fault <= 1'b0;
        end else if (m_act) begin
            if (e_done) m_act <= 1'b0;
            else        m_age <= m_age + 1;
            if (e_err)  m_fault <= 1'b1;
        end else begin
            case (winner(bus.iREN, bus.dREN | bus.dWEN, m_last))
                1: begin
                    m_act <= 1'b1; m_side <= ARB_I; m_last <= ARB_I; m_age <= 0;
                    m_addr <= bus.iaddr; m_data <= '0; m_wr <= 1'b0;
                end
                2: begin
                    m_act <= 1'b1; m_side <= ARB_D; m_last <= ARB_D; m_age <= 0;
                    m_addr <= bus.daddr; m_data <= bus.dstore; m_wr <= bus.dWEN;
                end
                default: ;
            endcase
        end
    end

    logic  x_ren, x_wen, x_iwait, x_dwait, x_fault;
    word_t x_addr, x_store, x_iload, x_dload;
    always_comb begin
        x_ren   = m_act && !m_wr;
        x_wen   = m_act &&  m_wr;
        x_addr  = m_act ? m_addr : '0;
        x_store = m_act ? m_data : '0;
        x_iwait = !(m_act && (m_side == ARB_I) && e_done);
        x_dwait = !(m_act && (m_side == ARB_D) && e_done);
        x_iload = (m_act && (m_side == ARB_I) && e_access) ? bus.ramload : '0;
        x_dload = (m_act && (m_side == ARB_D) && e_access && !m_wr) ? bus.ramload : '0;
        x_fault = m_fault;
    end

    always @(negedge CLK) begin
        if (run) begin
            chk("m_ramREN",   32'(bus.ramREN), 32'(x_ren));
            chk("m_ramWEN",   32'(bus.ramWEN), 32'(x_wen));
            chk("m_ramaddr",  bus.ramaddr,     x_addr);
            chk("m_ramstore", bus.ramstore,    x_store);
            chk("m_iwait",    32'(bus.iwait),  32'(x_iwait));
            chk("m_dwait",    32'(bus.dwait),  32'(x_dwait));
            chk("m_iload",    bus.iload,       x_iload);
            chk("m_dload",    bus.dload,       x_dload);
            chk("m_fault",    32'(bus.fault),  32'(x_fault));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0;

        // reset values
        #2;
        chk("rst_iwait",  32'(bus.iwait),  32'd1);
        chk("rst_dwait",  32'(bus.dwait),  32'd1);
        chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("rst_ramaddr", bus.ramaddr,    32'h0);
        chk("rst_iload",   bus.iload,      32'h0);
        chk("rst_fault",  32'(bus.fault),  32'd0);
        repeat (2) tick();
        nRST = 1'b1;
        tick();

        // solo fetch, one BUSY cycle then ACCESS
        ram_lat = 1; bus.ramload = 32'h00011082;
        bus.iREN = 1'b1; bus.iaddr = 32'h4;
        @(negedge CLK); chk("fetch_idle_iwait", 32'(bus.iwait), 32'd1);
        tick(); @(negedge CLK);
        chk("fetch_ramREN",  32'(bus.ramREN), 32'd1);
        chk("fetch_ramaddr", bus.ramaddr,     32'h4);
        chk("fetch_busy_iwait", 32'(bus.iwait), 32'd1);
        tick(); @(negedge CLK);
        chk("fetch_done_iwait", 32'(bus.iwait), 32'd0);
        chk("fetch_iload",      bus.iload,      32'h00011082);
        chk("fetch_dwait",      32'(bus.dwait), 32'd1);
        tick(); bus.iREN = 1'b0;
        @(negedge CLK);
        chk("fetch_after_iwait",  32'(bus.iwait),  32'd1);
        chk("fetch_after_ramREN", 32'(bus.ramREN), 32'd0);
        tick();

        // contention from reset: D first, then alternating
        nRST = 1'b0; tick(); nRST = 1'b1;
        ram_lat = 0; bus.ramload = 32'hDEAD0001;
        bus.iREN = 1'b1; bus.iaddr = 32'h100;
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        for (int k = 1; k <= 6; k++) begin
            tick(); @(negedge CLK);
            case (k)
                1, 5: begin
                    chk("cont_d_dwait",   32'(bus.dwait), 32'd0);
                    chk("cont_d_iwait",   32'(bus.iwait), 32'd1);
                    chk("cont_d_ramaddr", bus.ramaddr,    32'h200);
                    chk("cont_d_dload",   bus.dload,      32'hDEAD0001);
                end
                3: begin
                    chk("cont_i_iwait",   32'(bus.iwait), 32'd0);
                    chk("cont_i_dwait",   32'(bus.dwait), 32'd1);
                    chk("cont_i_ramaddr", bus.ramaddr,    32'h100);
                    chk("cont_i_iload",   bus.iload,      32'hDEAD0001);
                end
                default: begin
                    chk("cont_idle_iwait",  32'(bus.iwait),  32'd1);
                    chk("cont_idle_dwait",  32'(bus.dwait),  32'd1);
                    chk("cont_idle_ramREN", 32'(bus.ramREN), 32'd0);
                end
            endcase
        end
        bus.iREN = 1'b0; bus.dREN = 1'b0;
        tick();

        // store with address change mid-grant
        ram_lat = 2;
        bus.dWEN = 1'b1; bus.daddr = 32'h3C; bus.dstore = 32'hA52D;
        tick(); @(negedge CLK);
        chk("st_ramWEN",   32'(bus.ramWEN), 32'd1);
        chk("st_ramREN",   32'(bus.ramREN), 32'd0);
        chk("st_ramaddr",  bus.ramaddr,     32'h3C);
        chk("st_ramstore", bus.ramstore,    32'hA52D);
        tick(); bus.daddr = 32'h40;
        @(negedge CLK);
        chk("st_mid_ramaddr",  bus.ramaddr,     32'h3C);
        chk("st_mid_ramstore", bus.ramstore,    32'hA52D);
        chk("st_mid_dwait",    32'(bus.dwait),  32'd1);
        tick(); @(negedge CLK);
        chk("st_done_dwait",   32'(bus.dwait),  32'd0);
        chk("st_done_dload",   bus.dload,       32'h0);
        chk("st_done_ramaddr", bus.ramaddr,     32'h3C);
        tick(); bus.dWEN = 1'b0;
        @(negedge CLK); chk("st_after_ramWEN", 32'(bus.ramWEN), 32'd0);

        // timeout with RAM stuck BUSY
        tick(); ram_hang = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h80;
        tick(); tick(); tick(); @(negedge CLK);
        chk("to_c3_dwait", 32'(bus.dwait), 32'd1);
        chk("to_c3_fault", 32'(bus.fault), 32'd0);
        tick(); @(negedge CLK);
        chk("to_c4_dwait", 32'(bus.dwait), 32'd0);
        chk("to_c4_dload", bus.dload,      32'h0);
        chk("to_c4_fault", 32'(bus.fault), 32'd0);
        tick(); bus.dREN = 1'b0; ram_hang = 1'b0;
        @(negedge CLK);
        chk("to_c5_fault",  32'(bus.fault),  32'd1);
        chk("to_c5_ramREN", 32'(bus.ramREN), 32'd0);
        chk("to_c5_dwait",  32'(bus.dwait),  32'd1);

        // ERROR on first fetch cycle, then a clean fetch
        tick(); nRST = 1'b0; tick(); nRST = 1'b1;
        ram_err = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h8;
        @(negedge CLK); chk("err_c0_fault", 32'(bus.fault), 32'd0);
        tick(); @(negedge CLK);
        chk("err_iwait",  32'(bus.iwait),  32'd0);
        chk("err_iload",  bus.iload,       32'h0);
        chk("err_ramREN", 32'(bus.ramREN), 32'd1);
        tick(); bus.iREN = 1'b0; ram_err = 1'b0;
        @(negedge CLK);
        chk("err_fault_set", 32'(bus.fault), 32'd1);
        chk("err_idle_iwait", 32'(bus.iwait), 32'd1);
        tick(); ram_lat = 0; bus.ramload = 32'h2402000A;
        bus.iREN = 1'b1; bus.iaddr = 32'hC;
        tick(); @(negedge CLK);
        chk("err_next_iwait",   32'(bus.iwait), 32'd0);
        chk("err_next_iload",   bus.iload,      32'h2402000A);
        chk("err_next_ramaddr", bus.ramaddr,    32'hC);
        chk("err_next_fault",   32'(bus.fault), 32'd1);
        tick(); bus.iREN = 1'b0;

        // reset in the middle of a write grant
        tick(); ram_lat = 3;
        bus.dWEN = 1'b1; bus.daddr = 32'h44; bus.dstore = 32'h1234;
        tick(); @(negedge CLK);
        chk("rmid_ramWEN_before", 32'(bus.ramWEN), 32'd1);
        #2; nRST = 1'b0; bus.dWEN = 1'b0;
        #1;
        chk("rmid_ramWEN",   32'(bus.ramWEN), 32'd0);
        chk("rmid_ramaddr",  bus.ramaddr,     32'h0);
        chk("rmid_ramstore", bus.ramstore,    32'h0);
        chk("rmid_dwait",    32'(bus.dwait),  32'd1);
        chk("rmid_iwait",    32'(bus.iwait),  32'd1);
        chk("rmid_dload",    bus.dload,       32'h0);
        chk("rmid_fault",    32'(bus.fault),  32'd0);
        tick(); tick(); nRST = 1'b1;
        repeat (3) begin
            tick(); @(negedge CLK);
            chk("rmid_idle_ramWEN", 32'(bus.ramWEN), 32'd0);
            chk("rmid_idle_ramREN", 32'(bus.ramREN), 32'd0);
        end

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
